// File: rtl/gpio_checkpoint_monitor.sv
// Checkpoint monitor: counts low-to-high transitions on NCH GPIO lines within a cycle budget.
// Optional macro CKM_GLITCH_FILTER_EN adds a 2-sample agreement filter after the synchronizer.

module ckm_lane #(
    parameter int EDGES = 2
) (
    input  logic clock,
    input  logic resetb,
    input  logic chk,
    input  logic go,
    input  logic en,
    input  logic tmo,
    output logic started,
    output logic pass,
    output logic fail,
    output logic fin
);
    typedef enum logic [2:0] {OFF, ARMED, RUN, PASS, FAIL} st_t;

    localparam logic [3:0] EDGES_C = 4'(EDGES);

    st_t        state, state_nx;
    logic [3:0] ecnt, ecnt_nx;
    logic       started_nx;
    logic       s1, s2, rise;

`ifdef CKM_GLITCH_FILTER_EN
    logic s3, filt;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s3   <= 1'b0;
            filt <= 1'b0;
        end else begin
            s1 <= chk;
            s2 <= s1;
            s3 <= s2;
            if (s2 == s3) filt <= s3;
        end
    end

    // Edge fires on the same cycle the filtered level flips, so only one cycle is added.
    assign rise = (s2 == s3) && s3 && !filt;
`else
    logic prev;

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= chk;
            s2   <= s1;
            prev <= s2;
        end
    end

    assign rise = s2 && !prev;
`endif

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            state   <= OFF;
            ecnt    <= '0;
            started <= 1'b0;
        end else begin
            state   <= state_nx;
            ecnt    <= ecnt_nx;
            started <= started_nx;
        end
    end

    // A completing edge is checked before timeout, so PASS wins a tie.
    always_comb begin
        state_nx   = state;
        ecnt_nx    = ecnt;
        started_nx = started;
        if (go) begin
            state_nx   = en ? ARMED : OFF;
            ecnt_nx    = '0;
            started_nx = 1'b0;
        end else begin
            case (state)
                ARMED: begin
                    if (rise) begin
                        started_nx = 1'b1;
                        ecnt_nx    = 4'd1;
                        state_nx   = (EDGES == 1) ? PASS : RUN;
                    end else if (tmo) begin
                        state_nx = FAIL;
                    end
                end
                RUN: begin
                    if (rise) begin
                        ecnt_nx = ecnt + 4'd1;
                        if (ecnt + 4'd1 == EDGES_C) state_nx = PASS;
                    end else if (tmo) begin
                        state_nx = FAIL;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pass = (state == PASS);
        fail = (state == FAIL);
        fin  = (state == OFF) || (state == PASS) || (state == FAIL);
    end
endmodule

module gpio_checkpoint_monitor #(
    parameter int NCH     = 4,
    parameter int EDGES   = 2,
    parameter int TMO_W   = 17,
    parameter int TIMEOUT = 70000
) (
    input  logic             clock,
    input  logic             resetb,
    input  logic [NCH-1:0]   chk_i,
    input  logic [NCH-1:0]   en_mask_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic [NCH-1:0]   started_o,
    output logic [NCH-1:0]   pass_o,
    output logic [NCH-1:0]   fail_o,
    output logic             done_o,
    output logic             all_pass_o,
    output logic             irq_o,
    output logic [TMO_W-1:0] cycles_o
);
    if ((TIMEOUT >> TMO_W) != 0 || NCH < 1 || NCH > 32 || EDGES < 1 || EDGES > 15) begin : g_param_chk
        $error("gpio_checkpoint_monitor: illegal parameters (TIMEOUT must fit in TMO_W bits)");
    end

    localparam logic [TMO_W-1:0] TMO_C = TMO_W'(TIMEOUT);

    logic [TMO_W-1:0] cnt;
    logic [NCH-1:0]   mask_q, lane_fin;
    logic             go, tmo, finish;

    assign go     = start_i && !busy_o;
    assign tmo    = busy_o && (cnt == TMO_C);
    assign finish = busy_o && (&lane_fin);

    ckm_lane #(.EDGES(EDGES)) u_lane [NCH-1:0] (
        .clock   (clock),
        .resetb  (resetb),
        .chk     (chk_i),
        .go      (go),
        .en      (en_mask_i),
        .tmo     (tmo),
        .started (started_o),
        .pass    (pass_o),
        .fail    (fail_o),
        .fin     (lane_fin)
    );

    // Counter holds at TIMEOUT; finish latches the pre-increment value.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            all_pass_o <= 1'b0;
            irq_o      <= 1'b0;
            cycles_o   <= '0;
            cnt        <= '0;
            mask_q     <= '0;
        end else begin
            irq_o <= 1'b0;
            if (go) begin
                busy_o     <= 1'b1;
                done_o     <= 1'b0;
                all_pass_o <= 1'b0;
                cnt        <= '0;
                mask_q     <= en_mask_i;
            end else if (busy_o) begin
                if (!tmo) cnt <= cnt + 1'b1;
                if (finish) begin
                    busy_o     <= 1'b0;
                    done_o     <= 1'b1;
                    irq_o      <= 1'b1;
                    cycles_o   <= cnt;
                    all_pass_o <= (|mask_q) && (pass_o == mask_q);
                end
            end
        end
    end
endmodule

// File: tb/tb_gpio_checkpoint_monitor.sv
// Directed bench for gpio_checkpoint_monitor (NCH=4, EDGES=2, TIMEOUT=1000).
module tb_gpio_checkpoint_monitor;
    localparam int TO = 1000;
`ifdef CKM_GLITCH_FILTER_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic        clock, resetb, start_i;
    logic [3:0]  chk_i, en_mask_i;
    logic        busy_o, done_o, all_pass_o, irq_o;
    logic [3:0]  started_o, pass_o, fail_o;
    logic [10:0] cycles_o;

    int n_chk = 0;
    int n_fail = 0;
    int irqs;

    gpio_checkpoint_monitor #(.NCH(4), .EDGES(2), .TMO_W(11), .TIMEOUT(TO)) dut (
        .clock(clock), .resetb(resetb), .chk_i(chk_i), .en_mask_i(en_mask_i),
        .start_i(start_i), .busy_o(busy_o), .started_o(started_o), .pass_o(pass_o),
        .fail_o(fail_o), .done_o(done_o), .all_pass_o(all_pass_o), .irq_o(irq_o),
        .cycles_o(cycles_o)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic start(input logic [3:0] m);
        en_mask_i = m;
        start_i   = 1'b1;
        tick();
        start_i   = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        irqs = 0;
        for (int i = 0; i < budget && !done_o; i++) begin
            tick();
            if (irq_o) irqs++;
        end
        check("done_wait", 32'(done_o), 1);
        repeat (3) begin
            tick();
            if (irq_o) irqs++;
        end
    endtask

    initial begin
        resetb = 1'b0; chk_i = '0; en_mask_i = '0; start_i = 1'b0;
        tick(2);
        check("rst_outs", {busy_o, done_o, all_pass_o, irq_o, started_o, pass_o, fail_o, 5'b0, cycles_o}, 0);
        resetb = 1'b1;
        tick(3);

        // basic high-low-high pass, plus sync latency
        start(4'b0001);
        check("t1_busy", 32'(busy_o), 1);
        chk_i = 4'b0001;
        tick(LAT - 1);
        check("t1_started_early", 32'(started_o), 0);
        tick(1);
        check("t1_started", 32'(started_o), 1);
        tick(50 - LAT);
        chk_i = 4'b0000;
        tick(50);
        chk_i = 4'b0001;
        wait_done(200);
        check("t1_pass", 32'(pass_o), 1);
        check("t1_fail", 32'(fail_o), 0);
        check("t1_all_pass", 32'(all_pass_o), 1);
        check("t1_irqs", 32'(irqs), 1);
        check("t1_cycles", 32'(cycles_o), 100 + LAT);
        check("t1_busy_end", 32'(busy_o), 0);
        chk_i = '0; tick(5);

        // ch1 never toggles: timeout
        start(4'b0011);
        chk_i = 4'b0001; tick(10);
        chk_i = 4'b0000; tick(10);
        chk_i = 4'b0001; tick(10);
        chk_i = 4'b0000;
        wait_done(1100);
        check("t2_pass", 32'(pass_o), 'h1);
        check("t2_fail", 32'(fail_o), 'h2);
        check("t2_started", 32'(started_o), 'h1);
        check("t2_all_pass", 32'(all_pass_o), 0);
        check("t2_cycles", 32'(cycles_o), TO);
        tick(5);

        // completing edge on the timeout cycle: pass wins
        start(4'b0001);
        chk_i = 4'b0001; tick(10);
        chk_i = 4'b0000; tick(TO + 1 - LAT - 10);
        chk_i = 4'b0001;
        wait_done(100);
        check("t3_pass", 32'(pass_o), 1);
        check("t3_fail", 32'(fail_o), 0);
        check("t3_all_pass", 32'(all_pass_o), 1);
        check("t3_cycles", 32'(cycles_o), TO);
        chk_i = '0; tick(5);

        // one cycle too late: fail
        start(4'b0001);
        chk_i = 4'b0001; tick(10);
        chk_i = 4'b0000; tick(TO + 2 - LAT - 10);
        chk_i = 4'b0001;
        wait_done(100);
        check("t3b_pass", 32'(pass_o), 0);
        check("t3b_fail", 32'(fail_o), 1);
        check("t3b_cycles", 32'(cycles_o), TO);
        chk_i = '0; tick(5);

        // reset mid-run
        start(4'b0001);
        chk_i = 4'b0001; tick(20);
        check("t4_started", 32'(started_o), 1);
        tick(480);
        resetb = 1'b0;
        #1;
        check("t4_rst_outs", {busy_o, done_o, all_pass_o, irq_o, started_o, pass_o, fail_o, 5'b0, cycles_o}, 0);
        chk_i = '0; tick(3);
        resetb = 1'b1;
        tick(5);
        check("t4_idle", 32'(busy_o), 0);
        start(4'b0001);
        chk_i = 4'b0001; tick(20);
        chk_i = 4'b0000; tick(20);
        chk_i = 4'b0001;
        wait_done(100);
        check("t4_pass", 32'(pass_o), 1);
        check("t4_cycles", 32'(cycles_o), 40 + LAT);
        chk_i = '0; tick(5);

        // start while busy is ignored; then empty-mask start
        start(4'b0001);
        chk_i = 4'b0001; tick(5);
        start(4'b0011);
        tick(14);
        chk_i = 4'b0000; tick(20);
        chk_i = 4'b0001;
        wait_done(100);
        check("t5_pass", 32'(pass_o), 1);
        check("t5_fail", 32'(fail_o), 0);
        check("t5_all_pass", 32'(all_pass_o), 1);
        check("t5_cycles", 32'(cycles_o), 40 + LAT);
        chk_i = '0; tick(5);
        start(4'b0000);
        check("t5_m0_busy", 32'(busy_o), 1);
        check("t5_m0_done_clr", 32'(done_o), 0);
        tick();
        check("t5_m0_done", 32'(done_o), 1);
        check("t5_m0_busy_end", 32'(busy_o), 0);
        check("t5_m0_all_pass", 32'(all_pass_o), 0);
        check("t5_m0_cycles", 32'(cycles_o), 0);
        check("t5_m0_irq", 32'(irq_o), 1);
        tick(5);

        // two single-cycle glitches
        start(4'b0001);
        tick(5);
        chk_i = 4'b0001; tick(1);
        chk_i = 4'b0000; tick(20);
        chk_i = 4'b0001; tick(1);
        chk_i = 4'b0000;
        wait_done(1100);
`ifdef CKM_GLITCH_FILTER_EN
        check("t6_pass", 32'(pass_o), 0);
        check("t6_fail", 32'(fail_o), 1);
        check("t6_cycles", 32'(cycles_o), TO);
`else
        check("t6_pass", 32'(pass_o), 1);
        check("t6_fail", 32'(fail_o), 0);
        check("t6_cycles", 32'(cycles_o), 26 + 3);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
